// File: rtl/wb_stage_ext.sv
// wb_stage_ext: MEM/WB latch with stall/flush, load extract/extend, wb mux, misalign flag, retired counter
module wb_stage_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [DATA_WIDTH-1:0]     i_dataread,
  input  logic [DATA_WIDTH-1:0]     i_address,
  input  logic [DATA_WIDTH-1:0]     i_pc_link,
  input  logic [1:0]                i_wb_sel,
  input  logic [1:0]                i_load_size,
  input  logic                      i_load_unsigned,
  input  logic                      i_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  output logic [DATA_WIDTH-1:0]     o_wb_data,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic                      o_regwrite,
  output logic                      o_valid,
  output logic                      o_misaligned,
  output logic [COUNT_WIDTH-1:0]    o_retired
);
  logic                      valid_q, rw_q, uns_q;
  logic [1:0]                sel_q, size_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     dr_q, addr_q, link_q, byte_sh, half_sh, ext;
  logic [COUNT_WIDTH-1:0]    cnt;
  logic                      capture;
  assign capture = !i_flush && !i_stall;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      uns_q   <= 1'b0;
      sel_q   <= '0;
      size_q  <= '0;
      rd_q    <= '0;
      dr_q    <= '0;
      addr_q  <= '0;
      link_q  <= '0;
      cnt     <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
    end else if (!i_stall) begin
      valid_q <= i_valid;
      rw_q    <= i_regwrite;
      uns_q   <= i_load_unsigned;
      sel_q   <= i_wb_sel;
      size_q  <= i_load_size;
      rd_q    <= i_rd;
      dr_q    <= i_dataread;
      addr_q  <= i_address;
      link_q  <= i_pc_link;
      if (capture && i_valid) cnt <= cnt + COUNT_WIDTH'(1);
    end
  assign byte_sh = dr_q >> {addr_q[1:0], 3'b000};
  assign half_sh = dr_q >> {addr_q[1], 4'b0000};
  always_comb begin
    ext = size_q == 2'b00 ? {{(DATA_WIDTH-8){~uns_q & byte_sh[7]}}, byte_sh[7:0]} :
          size_q == 2'b01 ? {{(DATA_WIDTH-16){~uns_q & half_sh[15]}}, half_sh[15:0]} : dr_q;
    o_misaligned = valid_q && sel_q == 2'b01 &&
                   ((size_q == 2'b01 && addr_q[0]) || (size_q[1] && addr_q[1:0] != 2'b00));
    o_wb_data = sel_q == 2'b00 ? addr_q : sel_q == 2'b01 ? ext : sel_q == 2'b10 ? link_q : '0;
    o_regwrite = valid_q && rw_q && rd_q != '0 && sel_q != 2'b11 && !o_misaligned;
  end
  assign o_rd      = rd_q;
  assign o_valid   = valid_q;
  assign o_retired = cnt;
endmodule

// File: tb/tb_wb_stage_ext.sv
// tb_wb_stage_ext: directed self-checking bench for wb_stage_ext (4-bit retired counter)
module tb_wb_stage_ext;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, stall, flush, uns, rw;
  logic [31:0] dr, addr, link;
  logic [1:0]  sel, size;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic [4:0]  o_rd;
  logic        o_rw, o_valid, o_mis;
  logic [3:0]  retired;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  wb_stage_ext #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(4)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_dataread(dr), .i_address(addr), .i_pc_link(link), .i_wb_sel(sel),
    .i_load_size(size), .i_load_unsigned(uns), .i_regwrite(rw), .i_rd(rd),
    .o_wb_data(wb_data), .o_rd(o_rd), .o_regwrite(o_rw), .o_valid(o_valid),
    .o_misaligned(o_mis), .o_retired(retired)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    valid = v; sel = s; size = sz; uns = u; addr = a; dr = d; rd = r; rw = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; link = '0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom); uns = 1'($urandom);
      rw = 1'($urandom); dr = $urandom; addr = $urandom; link = $urandom;
      sel = 2'($urandom); size = 2'($urandom); rd = 5'($urandom);
      step();
    end
    chk("rst_wb_data", wb_data, 0);
    chk("rst_rd", 32'(o_rd), 0);
    chk("rst_regwrite", 32'(o_rw), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_misaligned", 32'(o_mis), 0);
    chk("rst_retired", 32'(retired), 0);
    stall = 0; flush = 0; link = '0;
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0); rw = 0;
    #2 rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(o_valid), 0);
    chk("idle_wb_data", wb_data, 0);
    chk("idle_retired", 32'(retired), 0);
    drive(1, 2'b01, 2'b00, 0, 32'h1002, 32'h12F45678, 5);
    step();
    chk("lb_data", wb_data, 32'hFFFFFFF4);
    chk("lb_regwrite", 32'(o_rw), 1);
    chk("lb_rd", 32'(o_rd), 5);
    chk("lb_retired", 32'(retired), 1);
    drive(1, 2'b01, 2'b01, 1, 32'h1002, 32'h8001ABCD, 5);
    step();
    chk("lhu_data", wb_data, 32'h00008001);
    chk("lhu_regwrite", 32'(o_rw), 1);
    chk("lhu_mis", 32'(o_mis), 0);
    addr = 32'h1003;
    step();
    chk("lh_mis", 32'(o_mis), 1);
    chk("lh_mis_regwrite", 32'(o_rw), 0);
    chk("lh_mis_retired", 32'(retired), 3);
    drive(1, 2'b01, 2'b10, 0, 32'h1001, 32'hDEADBEEF, 6);
    step();
    chk("lw_mis", 32'(o_mis), 1);
    chk("lw_mis_regwrite", 32'(o_rw), 0);
    addr = 32'h1000;
    step();
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_mis_ok", 32'(o_mis), 0);
    chk("lw_regwrite", 32'(o_rw), 1);
    drive(1, 2'b01, 2'b00, 1, 32'h1003, 32'h9A000000, 7);
    step();
    chk("lbu_lane3", wb_data, 32'h0000009A);
    drive(1, 2'b01, 2'b01, 0, 32'h1000, 32'h0000F00F, 7);
    step();
    chk("lh_signed", wb_data, 32'hFFFFF00F);
    chk("lh_retired", 32'(retired), 7);
    drive(1, 2'b00, 2'b00, 0, 32'h55, 32'hFFFFFFFF, 3);
    step();
    chk("alu_data", wb_data, 32'h55);
    chk("alu_retired", 32'(retired), 8);
    stall = 1;
    drive(1, 2'b10, 2'b00, 0, 32'h99, 0, 7);
    step();
    chk("stall_data", wb_data, 32'h55);
    chk("stall_rd", 32'(o_rd), 3);
    chk("stall_regwrite", 32'(o_rw), 1);
    chk("stall_retired", 32'(retired), 8);
    flush = 1;
    step();
    chk("flush_valid", 32'(o_valid), 0);
    chk("flush_regwrite", 32'(o_rw), 0);
    chk("flush_retired", 32'(retired), 8);
    stall = 0; flush = 0;
    drive(1, 2'b10, 2'b00, 0, 32'h1234, 0, 31); link = 32'h00400008;
    step();
    chk("link_data", wb_data, 32'h00400008);
    chk("link_regwrite", 32'(o_rw), 1);
    rd = 0;
    step();
    chk("r0_regwrite", 32'(o_rw), 0);
    chk("r0_valid", 32'(o_valid), 1);
    rd = 9; sel = 2'b11;
    step();
    chk("rsv_data", wb_data, 0);
    chk("rsv_regwrite", 32'(o_rw), 0);
    chk("rsv_retired", 32'(retired), 11);
    valid = 0;
    step();
    chk("bubble_retired", 32'(retired), 11);
    stall = 1;
    drive(1, 2'b00, 2'b00, 0, 32'h77, 0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_retired", 32'(retired), 0);
    chk("arst_rd", 32'(o_rd), 0);
    stall = 0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      addr = 32'(i);
      step();
      if (i == 15) chk("wrap_15", 32'(retired), 15);
      if (i == 16) chk("wrap_0", 32'(retired), 0);
      if (i == 17) chk("wrap_1", 32'(retired), 1);
    end
    chk("wrap_data", wb_data, 17);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_stage_ext.md
Name: wb_stage_ext

Overview:
Parametrised writeback stage that replaces the plain memory/ALU result mux. It contains the MEM/WB pipeline latch with stall and flush control, and selects among ALU result, load data and link address. Load data is byte/half/word extracted and sign- or zero-extended. The block drives the register-file write port, flags misaligned loads and keeps a retired-instruction counter for the debug unit.

Parameters:
DATA_WIDTH, 32, datapath width in bits (multiple of 16, at least 32)
REG_ADDR_WIDTH, 5, register-file address width
COUNT_WIDTH, 16, width of the retired-instruction counter

Ports:
i_clock  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_valid  input  1  MEM stage holds a valid instruction
i_stall  input  1  hold the latch contents
i_flush  input  1  replace the latched entry with a bubble
i_dataread  input  DATA_WIDTH  raw word read from data memory
i_address  input  DATA_WIDTH  ALU result / memory address
i_pc_link  input  DATA_WIDTH  return address for JAL/JALR
i_wb_sel  input  2  00 ALU, 01 load, 10 link, 11 reserved
i_load_size  input  2  00 byte, 01 half, 10/11 word
i_load_unsigned  input  1  1 zero-extend, 0 sign-extend
i_regwrite  input  1  instruction writes a register
i_rd  input  REG_ADDR_WIDTH  destination register
o_wb_data  output  DATA_WIDTH  data to the register file
o_rd  output  REG_ADDR_WIDTH  latched destination
o_regwrite  output  1  qualified write enable
o_valid  output  1  latch holds a valid instruction
o_misaligned  output  1  latched load is misaligned
o_retired  output  COUNT_WIDTH  count of retired instructions

Behaviour:
- Reset (i_reset=0, async): all latch fields are 0, o_valid=0, o_regwrite=0, o_misaligned=0, o_wb_data=0, o_rd=0, o_retired=0.
- Latch update on rising edge, in priority order:
  - i_flush=1: valid and regwrite clear, other fields don't-care. Flush wins over stall.
  - i_stall=1: all fields hold.
  - Otherwise: capture every i_* field.
- Outputs are combinational from the latch only. Latency from input to output is 1 cycle. There is no combinational path from i_* to o_*.
- Load extraction is little-endian, using lane = latched address[1:0]:
  - Byte: selects dataread[8*lane+7 : 8*lane].
  - Half: selects dataread[16*addr[1]+15 : 16*addr[1]].
  - Word: passes the low DATA_WIDTH bits unchanged.
  - Extension: sign-extend from the top bit of the selected field unless unsigned=1, in which case zero-extend.
- o_misaligned = valid & (wb_sel==01) & one of:
  - half with addr[0]=1
  - word with addr[1:0]!=0
- o_wb_data by wb_sel: 00 gives the address field, 01 gives the extended load, 10 gives the link field, 11 gives 0.
- o_regwrite = valid & regwrite & (rd!=0) & (wb_sel!=11) & !o_misaligned. This means writes to r0 never assert, and misaligned or reserved selects suppress the write.
- o_retired increments by 1 on each edge where a new entry is captured with i_valid=1 (no flush, no stall). It wraps from all-ones to 0. Stalled and flushed cycles do not count. Misaligned loads do count.
- Reset asserted mid-stall or mid-flush clears everything immediately. The first capture after reset release follows the normal rules.

Test Plan:
- Reset: hold i_reset=0 with random inputs, release, then one edge with i_valid=0 -> all outputs 0 and o_retired=0.
- Load byte signed: i_dataread=0x12F45678, i_address=0x1002, size=00, unsigned=0, sel=01, rd=5, regwrite=1, valid=1 -> next cycle o_wb_data=0xFFFFFFF4, o_regwrite=1, o_rd=5, o_retired=1.
- Load half unsigned vs misaligned:
  - address=0x1002, size=01, unsigned=1, dataread=0x8001ABCD -> o_wb_data=0x00008001, o_regwrite=1.
  - address=0x1003 -> o_misaligned=1, o_regwrite=0.
- Stall/flush priority:
  - Capture an ALU write of 0x55 to rd=3, then assert i_stall with new inputs -> outputs hold 0x55/rd=3 and o_retired does not increment.
  - Assert i_stall and i_flush together -> o_valid=0, o_regwrite=0.
- Link and r0: sel=10, i_pc_link=0x00400008, rd=31 -> o_wb_data=0x00400008, o_regwrite=1. Same with rd=0 -> o_regwrite=0 while o_valid=1.
- Counter wrap: with COUNT_WIDTH=4, retire 17 valid instructions -> o_retired goes 15 then 0 then 1.
